// File: rtl/i2c_slave_regs.sv
// I2C slave with an 8-bit register file and pointer-based auto-increment access.
// A local host port shares the register file so bus-written values reach on-chip logic.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1C,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3,
    localparam int        PW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_index,
    output logic          busy
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t               state;
    logic [7:0]           regs [NREGS];
    logic [PW-1:0]        ptr;
    logic [7:0]           shreg;
    logic [7:0]           tx;
    logic [3:0]           bit_cnt;
    logic                 rw;

    logic [1:0]           raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [CW-1:0]        cnt_q [2];
    logic [1:0]           filt_q;
    logic                 scl_f, sda_f, scl_prev, sda_prev;
    logic                 scl_rise, scl_fall, start_det, stop_det;

    assign raw   = {scl_i, sda_i};
    assign scl_f = filt_q[1];
    assign sda_f = filt_q[0];

    // A filtered line follows its synchronised input only after FILT_LEN equal samples.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                cnt_q[i]  <= '0;
            end
            filt_q   <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                    if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
                        filt_q[i] <= sync_q[i][SYNC_STAGES-1];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NREGS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            shreg     <= '0;
            tx        <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            // NOTE: the register file is deliberately flop-based with a reset, since every register must read 8'h00 after rst_n.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (host_we && ({1'b0, host_addr} < (PW+1)'(NREGS)))
                regs[host_addr] <= host_wdata;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == SLAVE_ADDR) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    rw     <= shreg[0];
                                    busy   <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                if ({1'b0, shreg} < 9'(NREGS)) begin
                                    ptr    <= shreg[PW-1:0];
                                    state  <= PTR_ACK;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                // NOTE: this assignment follows the host write above, so on a same-index collision the I2C byte is the one stored.
                                regs[ptr] <= shreg;
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                                ptr       <= next_ptr(ptr);
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                tx     <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RACK;
                            end else begin
                                tx     <= {tx[6:0], 1'b0};
                                sda_oe <= ~tx[6];
                            end
                        end
                    end
                    RACK: begin
                        // ptr advances on the acknowledge bit whether or not the master wants more.
                        if (scl_rise) begin
                            ptr <= next_ptr(ptr);
                            if (sda_f) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            tx      <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            host_rdata <= 8'h00;
        else
            host_rdata <= ({1'b0, host_addr} < (PW+1)'(NREGS)) ? regs[host_addr] : 8'h00;
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-level I2C master model on an open-drain SDA
// plus host-port accesses, each result compared against hand-computed values.
module tb_i2c_slave_regs;

    localparam int T = 8;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic [3:0] idx_q[$];
    logic       oe_seen = 1'b0;

    assign sda_i = sda_m & ~sda_oe;

    always #5 sysclk = ~sysclk;

    i2c_slave_regs dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index),
        .busy       (busy)
    );

    always @(negedge sysclk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            idx_q.push_back(wr_index);
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // mode 1: one-cycle SDA glitch mid-high; mode 2: host write pulsed on the commit cycle.
    task automatic bus_bit(input logic b, input int mode, output logic line);
        sda_m = b;
        clks(T);
        scl_m = 1'b1;
        if (mode == 1) begin
            clks(T/2);
            sda_m = ~b;
            clks(1);
            sda_m = b;
            clks(T/2 - 1);
        end else begin
            clks(T);
        end
        line = sda_i;
        clks(T);
        scl_m = 1'b0;
        if (mode == 2) begin
            clks(5);
            host_we = 1'b1;
            clks(1);
            host_we = 1'b0;
            clks(T - 6);
        end else begin
            clks(T);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int mode, input int mode_bit, output logic acked);
        logic line;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == mode_bit) ? mode : 0, line);
        bus_bit(1'b1, 0, line);
        acked = ~line;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 0, line);
            d[i] = line;
        end
        bus_bit(~master_ack, 0, line);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clks(T);
        scl_m = 1'b1; clks(T);
        sda_m = 1'b0; clks(T);
        scl_m = 1'b0; clks(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clks(T);
        scl_m = 1'b1; clks(T);
        sda_m = 1'b1; clks(2*T);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        clks(1);
        host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        clks(1);
        d = host_rdata;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic       line;
        logic [7:0] d;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        host_addr = '0; host_we = 1'b0; host_wdata = '0;
        clks(3);
        rst_n = 1'b1;
        clks(2);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_host_rdata", host_rdata, 8'h00);

        host_write(4'd0, 8'hA5);
        host_read(4'd0, d);
        check("host_rw", d, 8'hA5);

        // reset asserted while the slave drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) bus_bit(logic'((8'h38 >> i) & 8'h01), 0, line);
        sda_m = 1'b1; clks(T);
        scl_m = 1'b1; clks(T);
        check("ack_driven", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_release", sda_oe, 0);
        clks(2);
        rst_n = 1'b1;
        clks(T);
        scl_m = 1'b0; clks(T);
        i2c_stop();
        host_read(4'd0, d);
        check("rst_reg_clear", d, 8'h00);
        check("rst_busy_after", busy, 0);

        // write 0x38, ptr 3, 0xAA, 0x55
        strobe_cnt = 0; idx_q.delete();
        i2c_start();
        send_byte(8'h38, 0, 0, ack); check("wr_addr_ack", ack, 1);
        check("wr_busy", busy, 1);
        send_byte(8'h03, 0, 0, ack); check("wr_ptr_ack", ack, 1);
        send_byte(8'hAA, 0, 0, ack); check("wr_d0_ack", ack, 1);
        send_byte(8'h55, 0, 0, ack); check("wr_d1_ack", ack, 1);
        i2c_stop();
        check("wr_busy_after_stop", busy, 0);
        check("wr_strobe_cnt", strobe_cnt, 2);
        check("wr_index0", (idx_q.size() > 0) ? idx_q[0] : 4'hF, 3);
        check("wr_index1", (idx_q.size() > 1) ? idx_q[1] : 4'hF, 4);
        host_read(4'd3, d); check("reg3", d, 8'hAA);
        host_read(4'd4, d); check("reg4", d, 8'h55);

        // pointer wrap 15 -> 0 -> 1
        i2c_start();
        send_byte(8'h38, 0, 0, ack);
        send_byte(8'h0F, 0, 0, ack); check("wrap_ptr_ack", ack, 1);
        send_byte(8'h11, 0, 0, ack);
        send_byte(8'h22, 0, 0, ack);
        send_byte(8'h33, 0, 0, ack); check("wrap_d2_ack", ack, 1);
        i2c_stop();
        host_read(4'd15, d); check("reg15", d, 8'h11);
        host_read(4'd0, d);  check("reg0", d, 8'h22);
        host_read(4'd1, d);  check("reg1", d, 8'h33);

        // pointer write, repeated START, three-byte read
        host_write(4'd2, 8'hC3);
        host_write(4'd3, 8'h5A);
        host_write(4'd4, 8'h0F);
        host_write(4'd5, 8'h96);
        host_write(4'd6, 8'h6B);
        i2c_start();
        send_byte(8'h38, 0, 0, ack);
        send_byte(8'h02, 0, 0, ack); check("rd_ptr_ack", ack, 1);
        i2c_start();
        send_byte(8'h39, 0, 0, ack); check("rd_addr_ack", ack, 1);
        recv_byte(1'b1, d); check("rd_byte0", d, 8'hC3);
        recv_byte(1'b1, d); check("rd_byte1", d, 8'h5A);
        recv_byte(1'b0, d); check("rd_byte2", d, 8'h0F);
        check("rd_release", sda_oe, 0);
        check("rd_busy_nack", busy, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'h39, 0, 0, ack);
        recv_byte(1'b0, d); check("rd_ptr_is_5", d, 8'h96);
        i2c_stop();

        // wrong address, then out-of-range pointer
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h3A, 0, 0, ack); check("bad_addr_nack", ack, 0);
        check("bad_addr_oe", oe_seen, 0);
        check("bad_addr_busy", busy, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'h38, 0, 0, ack);
        send_byte(8'h20, 0, 0, ack); check("bad_ptr_nack", ack, 0);
        check("bad_ptr_busy", busy, 0);
        i2c_stop();
        i2c_start();
        send_byte(8'h39, 0, 0, ack);
        recv_byte(1'b0, d); check("ptr_unchanged", d, 8'h6B);
        i2c_stop();

        // SDA glitch with SCL high, then host/I2C collision on index 4
        host_addr = 4'd4; host_wdata = 8'hEE;
        strobe_cnt = 0;
        i2c_start();
        send_byte(8'h38, 0, 0, ack);
        send_byte(8'h04, 1, 7, ack); check("glitch_ptr_ack", ack, 1);
        check("glitch_busy", busy, 1);
        send_byte(8'h77, 2, 0, ack); check("coll_ack", ack, 1);
        i2c_stop();
        check("coll_strobe_cnt", strobe_cnt, 1);
        host_read(4'd4, d); check("coll_i2c_wins", d, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Parametrised I2C slave with an internal register file, replacing the address-only slave used for bring-up. It filters and synchronises SCL/SDA, detects START, repeated START and STOP, matches a configurable 7-bit address, and supports pointer-based multi-byte writes and reads with auto-increment. A local host port gives on-chip logic read/write access to the same registers, so I2C configuration values reach the rest of the design.

## Interface
- SLAVE_ADDR, 7'h1C, 7-bit bus address answered with ACK
- NREGS, 16, number of 8-bit registers (2..256); PW = clog2(NREGS) pointer bits
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (≥2)
- FILT_LEN, 3, consecutive equal samples required before a filtered line changes (≥1)
- sysclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- scl_i  in  1  raw SCL from pad
- sda_i  in  1  raw SDA from pad
- sda_oe  out  1  1 = pull SDA low; pad drives SDA to 'z' otherwise
- host_addr  in  PW  host register index
- host_we  in  1  host write strobe
- host_wdata  in  8  host write data
- host_rdata  out  8  reg[host_addr], registered
- wr_strobe  out  1  one-cycle pulse when an I2C write commits a register
- wr_index  out  PW  index of committed register, valid with wr_strobe
- busy  out  1  1 between addressed START and STOP/NACK/return to IDLE

## Operation
- Input path: SYNC_STAGES flops, then a FILT_LEN-sample glitch filter per line; edge detection uses filtered scl_f/sda_f and their previous values.
- START: sda_f falls while scl_f=1 (any state, including mid-byte = repeated START) -> ADDR, bit counter 0. STOP: sda_f rises while scl_f=1 -> IDLE, sda_oe=0.
- Bits sampled on scl_f rising edge, MSB first; sda_oe changes only on scl_f falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- ADDR: 8 bits shifted in. On falling edge after bit 8: address == SLAVE_ADDR -> ADDR_ACK (sda_oe=1) else IDLE (no ACK, busy stays 0).
- ADDR_ACK ends on the next falling edge: R/W=0 -> PTR, sda_oe=0; R/W=1 -> RDATA, first bit of reg[ptr] driven (sda_oe = ~bit).
- PTR: byte < NREGS -> ptr loaded, ACK in PTR_ACK, then WDATA. Byte ≥ NREGS -> NACK, IDLE, ptr unchanged.
- WDATA: after 8th bit, reg[ptr] <= byte, wr_strobe=1 with wr_index=ptr, ACK, ptr <= ptr+1 wrapping NREGS-1 -> 0; WDATA_ACK -> WDATA.
- RDATA: 8 bits of reg[ptr] driven; sda_oe released after the 8th falling edge; RACK samples master bit on rising edge: 0 (ACK) -> ptr+1 (wrap), next byte loaded at falling edge, RDATA; 1 (NACK) -> IDLE.
- ptr persists across transactions (read without pointer write reuses last ptr).
- Host: host_we writes reg[host_addr] <= host_wdata. Same-cycle I2C commit to same index: I2C write wins; different indexes: both commit. Read data byte latched at start of each byte; later changes don't corrupt an in-flight byte.

## Timing
- Reset: state IDLE, sda_oe=0, ptr=0, all registers 8'h00, host_rdata=8'h00, wr_strobe=0, wr_index=0, busy=0, filters/synchronisers at 1 (bus idle).
- Pad-to-filtered latency: SYNC_STAGES + FILT_LEN sysclk cycles; sysclk ≥ 16× SCL frequency required.
- sda_oe update: 1 sysclk after detected scl_f fall.
- wr_strobe: single cycle, same cycle as register update; reg visible on host_rdata 1 cycle after that if host_addr matches.
- host_rdata latency: 1 sysclk from host_addr.
- rst_n low mid-transaction: immediate release of sda_oe (async), all state to reset values; bus ignored until next START.
- Glitches shorter than FILT_LEN cycles on either line produce no edge, START or STOP.

## Test plan
- Reset: rst_n low during ACK drive -> sda_oe=0 same cycle; after release all outputs at reset values, host_rdata=8'h00.
- Write 0x38,0x03,0xAA,0x55,STOP -> ACK on all 4 bytes; reg3=0xAA, reg4=0x55; two wr_strobe pulses with wr_index 3,4; busy low after STOP.
- Pointer 0x0F (NREGS=16) then 3 data bytes 0x11,0x22,0x33 -> reg15=0x11, reg0=0x22, reg1=0x33 (wrap).
- Write ptr 0x02, repeated START, 0x39, read 3 bytes ACK,ACK,NACK with reg2..4=0xC3,0x5A,0x0F -> SDA bits match, slave releases after NACK, ptr=5.
- Address 0x3A (0x1D write) -> no ACK, sda_oe stays 0, busy 0; pointer 0x20 -> NACK, ptr unchanged.
- 1-cycle SDA glitch while SCL high -> no START/STOP; host_we to index 4 in same cycle as I2C commit to 4 -> I2C value kept.
